// File: rtl/enemy_bullet_pool.sv
`default_nettype none
// ============================================================================
// Module   : enemy_bullet_pool
// Purpose  : Pool of N_BULLETS enemy projectiles that travel leftward toward
//            the player. On every frame tick each live bullet is stepped
//            left and tested against the player hitbox. The hitbox height
//            follows the squat state. Hits and shield blocks are reported as
//            registered one-cycle pulses.
// Option   : `define AIM_TRACK_EN makes each surviving bullet's y step one
//            pixel per tick toward yPlayer. The step happens after the
//            overlap test.
// Ports    : clk, rst_n (async, active-low)
//            tick               frame-update strobe; state changes only on tick
//            fire               fire request, sampled on tick
//            xEnemy/yEnemy      enemy centre (11b/10b signed)
//            xPlayer/yPlayer    player centre (11b/10b signed)
//            isSquat, defend    squat hitbox select, shield active
//            bx/by              packed per-slot bullet x (11b) / y (10b)
//            alive              per-slot occupied flags
//            ready              cooldown expired and a free slot exists
//            hit/hit_cnt        registered damage pulse and unblocked hit count
//            blocked            registered shield-absorb pulse
// Revision : 1.0  initial release
// ============================================================================
module enemy_bullet_pool #(
    parameter int N_BULLETS = 4,
    parameter int COOLDOWN  = 16,
    parameter int STEP_X    = 8,
    parameter int BULLET_HX = 4,
    parameter int BULLET_HY = 4,
    parameter int PLAYER_HX = 16,
    parameter int PLAYER_HY = 32,
    parameter int SQUAT_HY  = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                tick,
    input  logic                                fire,
    input  logic signed [10:0]                  xEnemy,
    input  logic signed [9:0]                   yEnemy,
    input  logic signed [10:0]                  xPlayer,
    input  logic signed [9:0]                   yPlayer,
    input  logic                                isSquat,
    input  logic                                defend,
    output logic signed [11*N_BULLETS-1:0]      bx,
    output logic signed [10*N_BULLETS-1:0]      by,
    output logic        [N_BULLETS-1:0]         alive,
    output logic                                ready,
    output logic                                hit,
    output logic        [$clog2(N_BULLETS+1)-1:0] hit_cnt,
    output logic                                blocked
);

    localparam int HCW = $clog2(N_BULLETS + 1);
    localparam int CDW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam int IW  = (N_BULLETS > 1) ? $clog2(N_BULLETS) : 1;

    localparam logic signed [11:0] C_STEP_X    = 12'(STEP_X);
    localparam logic signed [11:0] C_BULLET_HX = 12'(BULLET_HX);
    localparam logic signed [11:0] C_BULLET_HY = 12'(BULLET_HY);
    localparam logic signed [11:0] C_PLAYER_HX = 12'(PLAYER_HX);
    localparam logic signed [11:0] C_PLAYER_HY = 12'(PLAYER_HY);
    localparam logic signed [11:0] C_SQUAT_HY  = 12'(SQUAT_HY);
    localparam logic signed [10:0] C_SPAWN_OFS = 11'(PLAYER_HX + BULLET_HX);
    localparam logic [CDW-1:0]     C_COOLDOWN  = CDW'(COOLDOWN);

    logic signed [10:0]     x_q [N_BULLETS];
    logic signed [10:0]     x_d [N_BULLETS];
    logic signed [9:0]      y_q [N_BULLETS];
    logic signed [9:0]      y_d [N_BULLETS];
    logic [N_BULLETS-1:0]   alive_q, alive_d;
    logic [CDW-1:0]         cooldown_q, cooldown_d;
    logic                   hit_q, hit_d;
    logic                   blocked_q, blocked_d;
    logic [HCW-1:0]         hit_cnt_q, hit_cnt_d;

    // Player hitbox window, shared by all slots (12-bit signed so the
    // +/- half-width never wraps at the 11-bit screen edge).
    logic signed [11:0]     w_px_lo, w_px_hi, w_py, w_ylim;
    assign w_px_hi = $signed({xPlayer[10], xPlayer}) + C_PLAYER_HX;
    assign w_px_lo = $signed({xPlayer[10], xPlayer}) - C_PLAYER_HX;
    assign w_py    = $signed({{2{yPlayer[9]}}, yPlayer});
    assign w_ylim  = C_BULLET_HY + (isSquat ? C_SQUAT_HY : C_PLAYER_HY);

    logic signed [11:0]     w_nx [N_BULLETS];
    logic signed [9:0]      w_ny [N_BULLETS];
    logic [N_BULLETS-1:0]   w_overlap, w_offedge;

    generate
        for (genvar gi = 0; gi < N_BULLETS; gi++) begin : g_slot
            logic signed [11:0] w_dy, w_ady;
            assign w_nx[gi]  = $signed({x_q[gi][10], x_q[gi]}) - C_STEP_X;
            assign w_dy      = $signed({{2{y_q[gi][9]}}, y_q[gi]}) - w_py;
            assign w_ady     = w_dy[11] ? -w_dy : w_dy;
            // Overlap is tested at the post-move position nx.
            assign w_overlap[gi] = (w_nx[gi] - C_BULLET_HX < w_px_hi) &&
                                   (w_nx[gi] + C_BULLET_HX > w_px_lo) &&
                                   (w_ady < w_ylim);
            assign w_offedge[gi] = (w_nx[gi] < C_BULLET_HX);
`ifdef AIM_TRACK_EN
            assign w_ny[gi] = (y_q[gi] < yPlayer) ? y_q[gi] + 10'sd1 :
                              (y_q[gi] > yPlayer) ? y_q[gi] - 10'sd1 :
                                                    y_q[gi];
`else
            assign w_ny[gi] = y_q[gi];
`endif
            assign bx[11*gi +: 11] = x_q[gi];
            assign by[10*gi +: 10] = y_q[gi];
        end
    endgenerate

    // Lowest-index free slot, judged on the pre-tick alive vector so that a
    // slot retired this tick is not reused until the next one.
    logic           w_free_found;
    logic [IW-1:0]  w_free_idx;
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = N_BULLETS - 1; i >= 0; i--) begin
            if (!alive_q[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IW'(i);
            end
        end
    end

    logic               w_spawn;
    logic signed [10:0] w_spawn_x;
    assign w_spawn   = tick && fire && (cooldown_q == '0) && w_free_found;
    assign w_spawn_x = xEnemy - C_SPAWN_OFS;

    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        alive_d    = alive_q;
        cooldown_d = cooldown_q;
        hit_cnt_d  = '0;
        hit_d      = 1'b0;
        blocked_d  = 1'b0;
        if (tick) begin
            for (int i = 0; i < N_BULLETS; i++) begin
                if (alive_q[i]) begin
                    if (w_overlap[i]) begin
                        alive_d[i] = 1'b0;
                        if (defend) begin
                            blocked_d = 1'b1;
                        end else begin
                            hit_cnt_d = hit_cnt_d + HCW'(1);
                        end
                    end else if (w_offedge[i]) begin
                        alive_d[i] = 1'b0;
                    end else begin
                        x_d[i] = w_nx[i][10:0];
                        y_d[i] = w_ny[i];
                    end
                end
            end
            hit_d = (hit_cnt_d != '0);
            // The spawned slot was free before the tick, so it never collides
            // with the move/retire updates above.
            if (w_spawn) begin
                alive_d[w_free_idx] = 1'b1;
                x_d[w_free_idx]     = w_spawn_x;
                y_d[w_free_idx]     = yEnemy;
                cooldown_d          = C_COOLDOWN;
            end else if (cooldown_q != '0) begin
                cooldown_d = cooldown_q - CDW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_BULLETS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
            alive_q    <= '0;
            cooldown_q <= '0;
            hit_q      <= 1'b0;
            hit_cnt_q  <= '0;
            blocked_q  <= 1'b0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            alive_q    <= alive_d;
            cooldown_q <= cooldown_d;
            hit_q      <= hit_d;
            hit_cnt_q  <= hit_cnt_d;
            blocked_q  <= blocked_d;
        end
    end

    assign alive   = alive_q;
    assign ready   = (cooldown_q == '0) && !(&alive_q);
    assign hit     = hit_q;
    assign hit_cnt = hit_cnt_q;
    assign blocked = blocked_q;

endmodule
`default_nettype wire
